mem_arb4: RTL and testbench



---
 rtl/mem_arb4.sv | 162 ++++++++++++++++
 tb/tb_mem_arb4.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb4.sv
// Four-port Avalon-MM arbiter: serializes single-word transfers from four masters
// onto one 36-bit memory slave, round-robin or fixed priority.
module mem_arb4 #(
  parameter int unsigned FIXED_PRIO = 0,
  localparam int unsigned AW = 18,
  localparam int unsigned DW = 36
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] s0_address,
  input  logic          s0_read,
  input  logic          s0_write,
  input  logic [DW-1:0] s0_writedata,
  output logic [DW-1:0] s0_readdata,
  output logic          s0_waitrequest,
  input  logic [AW-1:0] s1_address,
  input  logic          s1_read,
  input  logic          s1_write,
  input  logic [DW-1:0] s1_writedata,
  output logic [DW-1:0] s1_readdata,
  output logic          s1_waitrequest,
  input  logic [AW-1:0] s2_address,
  input  logic          s2_read,
  input  logic          s2_write,
  input  logic [DW-1:0] s2_writedata,
  output logic [DW-1:0] s2_readdata,
  output logic          s2_waitrequest,
  input  logic [AW-1:0] s3_address,
  input  logic          s3_read,
  input  logic          s3_write,
  input  logic [DW-1:0] s3_writedata,
  output logic [DW-1:0] s3_readdata,
  output logic          s3_waitrequest,
  output logic [AW-1:0] m_address,
  output logic          m_read,
  output logic          m_write,
  output logic [DW-1:0] m_writedata,
  input  logic [DW-1:0] m_readdata,
  input  logic          m_waitrequest
);

  localparam int unsigned NP = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    last_q, last_d;
  logic [NP-1:0] ack_q, ack_d;
  logic          m_read_d, m_write_d;
  logic [AW-1:0] m_address_d;
  logic [DW-1:0] m_writedata_d;
  logic [DW-1:0] rdata_q [NP];
  logic [DW-1:0] rdata_d [NP];

  logic [NP-1:0] req, wr;
  logic [AW-1:0] addr_in  [NP];
  logic [DW-1:0] wdata_in [NP];
  logic          found;
  logic [1:0]    win, cand;

  assign req = {s3_read | s3_write, s2_read | s2_write, s1_read | s1_write, s0_read | s0_write};
  assign wr  = {s3_write, s2_write, s1_write, s0_write};

  assign addr_in[0]  = s0_address;
  assign addr_in[1]  = s1_address;
  assign addr_in[2]  = s2_address;
  assign addr_in[3]  = s3_address;
  assign wdata_in[0] = s0_writedata;
  assign wdata_in[1] = s1_writedata;
  assign wdata_in[2] = s2_writedata;
  assign wdata_in[3] = s3_writedata;

  assign s0_readdata = rdata_q[0];
  assign s1_readdata = rdata_q[1];
  assign s2_readdata = rdata_q[2];
  assign s3_readdata = rdata_q[3];

  // Stalls come straight off the ack register so no input reaches them combinationally.
  assign s0_waitrequest = ~ack_q[0];
  assign s1_waitrequest = ~ack_q[1];
  assign s2_waitrequest = ~ack_q[2];
  assign s3_waitrequest = ~ack_q[3];

  // Next-state, arbitration and next values of every registered output.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    ack_d         = ack_q;
    m_read_d      = m_read;
    m_write_d     = m_write;
    m_address_d   = m_address;
    m_writedata_d = m_writedata;
    for (int unsigned p = 0; p < NP; p++) rdata_d[p] = rdata_q[p];
    found = 1'b0;
    win   = 2'd0;
    cand  = 2'd0;

    // Round-robin starts the search just after the previous winner.
    for (int unsigned i = 0; i < NP; i++) begin
      cand = (FIXED_PRIO != 0) ? 2'(i) : 2'(last_q + 2'(i + 1));
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d       = win;
          last_d        = win;
          m_address_d   = addr_in[win];
          m_writedata_d = wdata_in[win];
          m_write_d     = wr[win];
          m_read_d      = ~wr[win];
          state_d       = BUSY;
        end
      end
      BUSY: begin
        if (!m_waitrequest) begin
          m_read_d       = 1'b0;
          m_write_d      = 1'b0;
          ack_d[grant_q] = 1'b1;
          if (m_read) rdata_d[grant_q] = m_readdata;
          state_d        = DONE;
        end
      end
      DONE: begin
        ack_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 2'd0;
      last_q      <= 2'd3;
      ack_q       <= '0;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_address   <= '0;
      m_writedata <= '0;
      for (int unsigned p = 0; p < NP; p++) rdata_q[p] <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      ack_q       <= ack_d;
      m_read      <= m_read_d;
      m_write     <= m_write_d;
      m_address   <= m_address_d;
      m_writedata <= m_writedata_d;
      for (int unsigned p = 0; p < NP; p++) rdata_q[p] <= rdata_d[p];
    end
  end

endmodule

// File: tb/tb_mem_arb4.sv
// Bench for mem_arb4: a round-robin and a fixed-priority instance driven by directed and
// random requesters, checked against a transfer-level model of the arbiter and memory.
module tb_mem_arb4;
  localparam int NI = 2;
  localparam int NP = 4;
  localparam logic [17:0] RD_ADDR = 18'o1234;
  localparam logic [35:0] RD_PAT  = 36'o123456701234;
  localparam logic [17:0] WR_ADDR = 18'o377777;
  localparam logic [35:0] WR_PAT  = 36'o777777000000;

  logic        clk;
  logic        reset;
  logic [17:0] s_addr  [NI][NP];
  logic        s_rd    [NI][NP];
  logic        s_wr    [NI][NP];
  logic [35:0] s_wd    [NI][NP];
  logic [35:0] s_rdata [NI][NP];
  logic        s_wait  [NI][NP];
  logic [17:0] m_address [NI];
  logic        m_read    [NI];
  logic        m_write   [NI];
  logic [35:0] m_wdata   [NI];
  logic [35:0] m_rdata   [NI];
  logic        m_wait    [NI];

  // Instance 0 is round-robin, instance 1 fixed priority.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_arb4 #(.FIXED_PRIO(g)) u_dut (
      .clk(clk), .reset(reset),
      .s0_address(s_addr[g][0]), .s0_read(s_rd[g][0]), .s0_write(s_wr[g][0]),
      .s0_writedata(s_wd[g][0]), .s0_readdata(s_rdata[g][0]), .s0_waitrequest(s_wait[g][0]),
      .s1_address(s_addr[g][1]), .s1_read(s_rd[g][1]), .s1_write(s_wr[g][1]),
      .s1_writedata(s_wd[g][1]), .s1_readdata(s_rdata[g][1]), .s1_waitrequest(s_wait[g][1]),
      .s2_address(s_addr[g][2]), .s2_read(s_rd[g][2]), .s2_write(s_wr[g][2]),
      .s2_writedata(s_wd[g][2]), .s2_readdata(s_rdata[g][2]), .s2_waitrequest(s_wait[g][2]),
      .s3_address(s_addr[g][3]), .s3_read(s_rd[g][3]), .s3_write(s_wr[g][3]),
      .s3_writedata(s_wd[g][3]), .s3_readdata(s_rdata[g][3]), .s3_waitrequest(s_wait[g][3]),
      .m_address(m_address[g]), .m_read(m_read[g]), .m_write(m_write[g]),
      .m_writedata(m_wdata[g]), .m_readdata(m_rdata[g]), .m_waitrequest(m_wait[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total, bad, cyc;

  // Transfer-level model: phase 0 = bus free, 1 = strobe on the bus, 2 = completion cycle.
  int          phase [NI];
  int          cur   [NI];
  int          last  [NI];
  logic        exp_mr   [NI];
  logic        exp_mw   [NI];
  logic [17:0] exp_addr [NI];
  logic [35:0] exp_wd   [NI];
  logic [3:0]  exp_ack  [NI];
  logic [35:0] exp_rd   [NI][NP];
  logic [35:0] mem [int];

  // Requesters and slave behaviour.
  int          cnt    [NI][NP];
  int          kind   [NI][NP];
  logic        q_rd   [NI][NP];
  logic        q_wr   [NI][NP];
  logic [17:0] q_addr [NI][NP];
  logic [35:0] q_wd   [NI][NP];
  int          hold     [NI];
  bit          rnd_wait [NI];

  // Observations of the DUT.
  int alog [NI][64];
  int alen [NI];
  int n_mr [NI];
  int n_mw [NI];
  int rise_cyc [NI];
  int ack_cyc  [NI];
  bit prev_stb [NI];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int mkey(input int d, input logic [17:0] a);
    return d * 262144 + int'(a);
  endfunction

  function automatic logic [35:0] mem_get(input int d, input logic [17:0] a);
    int k;
    k = mkey(d, a);
    if (mem.exists(k)) return mem[k];
    return {4'(k), 32'(k) * 32'h9E3779B1};
  endfunction

  task automatic new_req(input int d, input int p);
    int op;
    q_addr[d][p] = 18'($urandom_range(0, 15));
    q_wd[d][p]   = {4'($urandom), 32'($urandom)};
    op = (kind[d][p] == 0) ? int'($urandom_range(1, 3)) : kind[d][p];
    q_rd[d][p] = (op == 1) || (op == 3);
    q_wr[d][p] = (op == 2) || (op == 3);
  endtask

  task automatic reset_model();
    for (int d = 0; d < NI; d++) begin
      phase[d] = 0; cur[d] = 0; last[d] = 3;
      exp_mr[d] = 1'b0; exp_mw[d] = 1'b0; exp_addr[d] = '0; exp_wd[d] = '0; exp_ack[d] = '0;
      hold[d] = 0; rnd_wait[d] = 1'b0; prev_stb[d] = 1'b0;
      for (int p = 0; p < NP; p++) begin
        exp_rd[d][p] = '0; cnt[d][p] = 0; kind[d][p] = 0;
      end
    end
  endtask

  // Advance the model over the edge just taken, using the inputs that edge sampled.
  task automatic model_step(input int d);
    int w, p;
    case (phase[d])
      0: begin
        w = -1;
        for (int k = 0; k < NP; k++) begin
          p = (d != 0) ? k : (last[d] + 1 + k) % NP;
          if (w < 0 && (s_rd[d][p] || s_wr[d][p])) w = p;
        end
        if (w >= 0) begin
          cur[d] = w; last[d] = w;
          exp_addr[d] = s_addr[d][w]; exp_wd[d] = s_wd[d][w];
          exp_mw[d] = s_wr[d][w]; exp_mr[d] = !s_wr[d][w];
          phase[d] = 1;
        end
      end
      1: begin
        if (!m_wait[d]) begin
          if (exp_mw[d]) mem[mkey(d, exp_addr[d])] = exp_wd[d];
          else exp_rd[d][cur[d]] = mem_get(d, exp_addr[d]);
          exp_mr[d] = 1'b0; exp_mw[d] = 1'b0;
          exp_ack[d] = 4'(1 << cur[d]);
          phase[d] = 2;
        end
      end
      default: begin
        exp_ack[d] = '0;
        phase[d] = 0;
      end
    endcase
  endtask

  task automatic check_outs(input int d);
    logic [3:0] wv, ew;
    for (int p = 0; p < NP; p++) wv[p] = s_wait[d][p];
    ew = ~exp_ack[d];
    chk($sformatf("m_read[%0d]", d), 64'(m_read[d]), 64'(exp_mr[d]));
    chk($sformatf("m_write[%0d]", d), 64'(m_write[d]), 64'(exp_mw[d]));
    chk($sformatf("m_address[%0d]", d), 64'(m_address[d]), 64'(exp_addr[d]));
    chk($sformatf("m_writedata[%0d]", d), 64'(m_wdata[d]), 64'(exp_wd[d]));
    chk($sformatf("waitrequest[%0d]", d), 64'(wv), 64'(ew));
    for (int p = 0; p < NP; p++)
      chk($sformatf("readdata[%0d][%0d]", d, p), 64'(s_rdata[d][p]), 64'(exp_rd[d][p]));
  endtask

  task automatic observe(input int d);
    bit stb;
    stb = m_read[d] || m_write[d];
    if (stb && !prev_stb[d]) rise_cyc[d] = cyc;
    prev_stb[d] = stb;
    if (m_read[d]) n_mr[d]++;
    if (m_write[d]) n_mw[d]++;
    for (int p = 0; p < NP; p++) begin
      if (s_wait[d][p] === 1'b0) begin
        if (alen[d] < 64) alog[d][alen[d]] = p;
        alen[d]++;
        ack_cyc[d] = cyc;
        if (cnt[d][p] > 0) begin
          cnt[d][p]--;
          if (cnt[d][p] > 0) new_req(d, p);
        end
      end
    end
  endtask

  task automatic drive(input int d);
    for (int p = 0; p < NP; p++) begin
      s_rd[d][p]   = (cnt[d][p] > 0) && q_rd[d][p];
      s_wr[d][p]   = (cnt[d][p] > 0) && q_wr[d][p];
      s_addr[d][p] = (cnt[d][p] > 0) ? q_addr[d][p] : 18'($urandom);
      s_wd[d][p]   = (cnt[d][p] > 0) ? q_wd[d][p] : {4'($urandom), 32'($urandom)};
    end
    if (phase[d] == 1) begin
      if (hold[d] > 0) begin
        m_wait[d] = 1'b1;
        hold[d]--;
      end else begin
        m_wait[d] = rnd_wait[d] ? ($urandom_range(0, 2) == 0) : 1'b0;
      end
    end else begin
      m_wait[d] = 1'($urandom_range(0, 1));
    end
    m_rdata[d] = mem_get(d, m_address[d]);
  endtask

  task automatic kick();
    for (int d = 0; d < NI; d++) drive(d);
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    for (int d = 0; d < NI; d++) begin
      model_step(d);
      check_outs(d);
      observe(d);
    end
    for (int d = 0; d < NI; d++) drive(d);
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    bit busy;
    n = 0;
    do begin
      cycle();
      n++;
      busy = 1'b0;
      for (int d = 0; d < NI; d++) begin
        if (phase[d] != 0) busy = 1'b1;
        for (int p = 0; p < NP; p++) if (cnt[d][p] > 0) busy = 1'b1;
      end
    end while (busy && n < budget);
    chk("cycle_budget", 64'(busy), 64'(0));
  endtask

  task automatic clear_obs();
    for (int d = 0; d < NI; d++) begin
      alen[d] = 0; n_mr[d] = 0; n_mw[d] = 0; rise_cyc[d] = -1; ack_cyc[d] = -1;
    end
  endtask

  task automatic set_req(input int d, input int p, input bit rd, input bit wr,
                         input logic [17:0] a, input logic [35:0] wd);
    kind[d][p] = 1; cnt[d][p] = 1;
    q_rd[d][p] = rd; q_wr[d][p] = wr; q_addr[d][p] = a; q_wd[d][p] = wd;
  endtask

  initial begin
    int kick_cyc, tot_req[NI];
    logic [35:0] saved;
    logic [17:0] a1;
    logic [35:0] w1;
    total = 0; bad = 0; cyc = 0;
    mem[mkey(0, RD_ADDR)] = RD_PAT;
    reset = 1'b1;
    reset_model();
    clear_obs();
    kick();
    @(negedge clk);
    kick();
    @(negedge clk);
    for (int d = 0; d < NI; d++) check_outs(d);
    reset = 1'b0;
    kick();

    // All four ports of the round-robin instance re-request after every ack;
    // the fixed-priority instance has ports 0 and 3 requesting, port 0 stops after six.
    for (int p = 0; p < NP; p++) begin
      kind[0][p] = 1; cnt[0][p] = 3; new_req(0, p);
    end
    kind[1][0] = 1; cnt[1][0] = 6; new_req(1, 0);
    kind[1][3] = 1; cnt[1][3] = 2; new_req(1, 3);
    rnd_wait[0] = 1'b1; rnd_wait[1] = 1'b1;
    kick();
    run_until_idle(300);
    chk("rr_grant_count", 64'(alen[0]), 64'(12));
    for (int i = 0; i < 12; i++) chk($sformatf("rr_grant%0d", i), 64'(alog[0][i]), 64'(i % 4));
    chk("fp_grant_count", 64'(alen[1]), 64'(8));
    for (int i = 0; i < 8; i++)
      chk($sformatf("fp_grant%0d", i), 64'(alog[1][i]), 64'((i < 6) ? 0 : 3));

    // Single zero-wait read on port 0.
    clear_obs();
    rnd_wait[0] = 1'b0; rnd_wait[1] = 1'b0;
    set_req(0, 0, 1'b1, 1'b0, RD_ADDR, '0);
    kick_cyc = cyc;
    kick();
    run_until_idle(20);
    chk("rd_strobe_cycles", 64'(n_mr[0]), 64'(1));
    chk("rd_strobe_latency", 64'(rise_cyc[0] - kick_cyc), 64'(1));
    chk("rd_ack_latency", 64'(ack_cyc[0] - kick_cyc), 64'(2));
    chk("rd_ack_count", 64'(alen[0]), 64'(1));
    chk("rd_data", 64'(s_rdata[0][0]), 64'(RD_PAT));

    // Port 2 write stalled five cycles by the slave.
    clear_obs();
    saved = exp_rd[0][2];
    set_req(0, 2, 1'b0, 1'b1, WR_ADDR, WR_PAT);
    hold[0] = 5;
    kick();
    run_until_idle(30);
    chk("wr_strobe_cycles", 64'(n_mw[0]), 64'(6));
    chk("wr_no_read", 64'(n_mr[0]), 64'(0));
    chk("wr_ack_after_strobe", 64'(ack_cyc[0] - rise_cyc[0]), 64'(6));
    chk("wr_ack_port", 64'(alog[0][0]), 64'(2));
    chk("wr_readdata_kept", 64'(s_rdata[0][2]), 64'(saved));

    // Read and write together on port 1 is a single write; read it back afterwards.
    clear_obs();
    a1 = 18'o2000;
    w1 = {4'($urandom), 32'($urandom)};
    set_req(0, 1, 1'b1, 1'b1, a1, w1);
    kick();
    run_until_idle(20);
    chk("rw_write_xfers", 64'(n_mw[0]), 64'(1));
    chk("rw_no_read", 64'(n_mr[0]), 64'(0));
    chk("rw_ack_count", 64'(alen[0]), 64'(1));
    set_req(0, 1, 1'b1, 1'b0, a1, '0);
    kick();
    run_until_idle(20);
    chk("rw_readback", 64'(s_rdata[0][1]), 64'(w1));

    // Random traffic with random slave stalls on both instances.
    clear_obs();
    for (int d = 0; d < NI; d++) begin
      rnd_wait[d] = 1'b1;
      tot_req[d] = 0;
      for (int p = 0; p < NP; p++) begin
        kind[d][p] = 0;
        cnt[d][p] = int'($urandom_range(0, 6));
        tot_req[d] += cnt[d][p];
        new_req(d, p);
      end
    end
    kick();
    run_until_idle(3000);
    for (int d = 0; d < NI; d++)
      chk($sformatf("random_acks[%0d]", d), 64'(alen[d]), 64'(tot_req[d]));

    // Asynchronous reset while a read is stalled on the bus.
    for (int d = 0; d < NI; d++) rnd_wait[d] = 1'b0;
    set_req(0, 0, 1'b1, 1'b0, RD_ADDR, '0);
    hold[0] = 10;
    kick();
    cycle();
    cycle();
    chk("pre_reset_m_read", 64'(m_read[0]), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("async_m_read", 64'(m_read[0]), 64'(0));
    chk("async_m_address", 64'(m_address[0]), 64'(0));
    for (int p = 0; p < NP; p++)
      chk($sformatf("async_wait%0d", p), 64'(s_wait[0][p]), 64'(1));
    reset_model();
    kick();
    @(negedge clk);
    for (int d = 0; d < NI; d++) check_outs(d);
    reset = 1'b0;
    kick();
    clear_obs();
    set_req(0, 0, 1'b1, 1'b0, RD_ADDR, '0);
    kick();
    run_until_idle(20);
    chk("post_reset_ack", 64'(alen[0]), 64'(1));
    chk("post_reset_data", 64'(s_rdata[0][0]), 64'(RD_PAT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
